debounce_sync: RTL and testbench

Multi-channel input conditioner that sits directly upstream of the team's D flip-flop and register stages. It takes raw asynchronous levels (buttons, switches, off-board strobes), synchronizes them into `clk`, and filters contact bounce with a per-channel stability counter. It presents clean, glitch-free levels plus single-cycle rise/fall pulses, so downstream `D` inputs never see metastable or bouncing data.

---
 rtl/debounce_sync.sv | 139 +++++++++++++
 tb/tb_debounce_sync.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: multi-channel input conditioner.
// Each channel passes a raw asynchronous level through a flop synchronizer
// and then through a stability counter. The debounced output q only flips
// after STABLE_CYCLES consecutive synchronized samples disagree with it.
// rise/fall are one-cycle pulses registered alongside q. busy is high while
// any channel has a qualification in progress.
//
// Build option: define DEBOUNCE_SYNC3_EN for a three-flop synchronizer
// (s1 -> s2 -> s3, filter fed from s3). All latencies grow by one clock.
// Ports and parameters are identical in both builds.
//
// Reset is asynchronous and active-low. It clears all state immediately,
// and its release is sampled by clk.

module debounce_sync #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    // Terminal count: a disagreeing sample seen while the counter holds this
    // value is the STABLE_CYCLES-th one in a row, so q flips on that edge.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Synchronizer stages. These are deliberately plain flops with no logic
    // between them, so that a metastable first stage has a full cycle to
    // resolve before it is used.
    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
`ifdef DEBOUNCE_SYNC3_EN
    logic [WIDTH-1:0] s3_reg;
`endif

    // Synchronized level that feeds the stability filter.
    logic [WIDTH-1:0] filt;

    // Per-channel counter-active flags, ORed together to form busy.
    logic [WIDTH-1:0] cnt_nz;

`ifdef DEBOUNCE_SYNC3_EN
    // Three-stage synchronizer for every channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign filt = s3_reg;
`else
    // Two-stage synchronizer for every channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
        end
    end

    assign filt = s2_reg;
`endif

    // One independent stability filter per channel.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             q_reg;
            logic             q_next;
            logic             rise_reg;
            logic             rise_next;
            logic             fall_reg;
            logic             fall_next;

            // Next-state decision. An agreeing sample discards all progress.
            // A disagreeing sample either advances the counter or, at the
            // terminal count, commits the new level and fires the matching
            // edge pulse. The counter is cleared on commit and therefore
            // never passes CNT_MAX.
            always_comb begin
                cnt_next  = cnt_reg;
                q_next    = q_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;
                if (filt[gi] == q_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    cnt_next  = '0;
                    q_next    = filt[gi];
                    rise_next = filt[gi];
                    fall_next = ~filt[gi];
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Counter, level and edge pulses all update on the same edge, so
            // the pulses line up exactly with the cycle in which q changes.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg  <= '0;
                    q_reg    <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    q_reg    <= q_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                end
            end

            assign q[gi]      = q_reg;
            assign rise[gi]   = rise_reg;
            assign fall[gi]   = fall_reg;
            assign cnt_nz[gi] = |cnt_reg;
        end
    endgenerate

    // busy is decoded directly from the counter registers, with no extra flop.
    assign busy = |cnt_nz;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed testbench for debounce_sync. The default geometry is 4 channels
// with STABLE_CYCLES = 8. The expected latency follows the build option.
// Inputs change 1 ns after a rising edge, so the next rising edge is the
// capture edge E0. Outputs are sampled 1 ns after each rising edge.

module tb_debounce_sync;

    localparam int STABLE = 8;
`ifdef DEBOUNCE_SYNC3_EN
    localparam int LAT = STABLE + 2;
`else
    localparam int LAT = STABLE + 1;
`endif
    // First and last edges, relative to E0, at which a counter is non-zero.
    localparam int BUSY_LO = LAT - STABLE + 1;
    localparam int BUSY_HI = LAT - 1;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    debounce_sync #(
        .WIDTH        (4),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset with din high, then release and check the clean step.
    task automatic test_reset();
        logic [3:0] eq, er;
        logic       eb;
        din   = 4'hF;
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if (q !== 4'h0)    begin n_err++; $display("FAIL reset_hold q=%h expected 0", q); end
        n_cmp++; if (rise !== 4'h0) begin n_err++; $display("FAIL reset_hold rise=%h expected 0", rise); end
        n_cmp++; if (fall !== 4'h0) begin n_err++; $display("FAIL reset_hold fall=%h expected 0", fall); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_hold busy=%b expected 0", busy); end
        $display("reset hold: q=%h rise=%h fall=%h busy=%b", q, rise, fall, busy);
        reset = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            eq = (k >= LAT) ? 4'hF : 4'h0;
            er = (k == LAT) ? 4'hF : 4'h0;
            eb = (k >= BUSY_LO) && (k <= BUSY_HI);
            n_cmp++; if (q !== eq)      begin n_err++; $display("FAIL step_q E%0d got %h expected %h", k, q, eq); end
            n_cmp++; if (rise !== er)   begin n_err++; $display("FAIL step_rise E%0d got %h expected %h", k, rise, er); end
            n_cmp++; if (fall !== 4'h0) begin n_err++; $display("FAIL step_fall E%0d got %h expected 0", k, fall); end
            n_cmp++; if (busy !== eb)   begin n_err++; $display("FAIL step_busy E%0d got %b expected %b", k, busy, eb); end
            $display("step E%0d: q=%h rise=%h busy=%b", k, q, rise, busy);
        end
    endtask

    // Starting from q=F: drop din[3] at edge 0 and din[0] at edge 4.
    task automatic test_independent_fall();
        logic [3:0] eq, ef;
        din = 4'b0111;
        for (int k = 0; k <= LAT + 6; k++) begin
            tick();
            if (k == 3) din = 4'b0110;
            eq = {(k < LAT), 1'b1, 1'b1, (k < LAT + 4)};
            ef = {(k == LAT), 1'b0, 1'b0, (k == LAT + 4)};
            n_cmp++; if (q !== eq)      begin n_err++; $display("FAIL indep_q E%0d got %h expected %h", k, q, eq); end
            n_cmp++; if (fall !== ef)   begin n_err++; $display("FAIL indep_fall E%0d got %h expected %h", k, fall, ef); end
            n_cmp++; if (rise !== 4'h0) begin n_err++; $display("FAIL indep_rise E%0d got %h expected 0", k, rise); end
            $display("indep E%0d: q=%h fall=%h", k, q, fall);
        end
    endtask

    // Bring every channel back to 0 so that later tests start clean.
    task automatic test_settle();
        din = 4'h0;
        repeat (LAT + 2) tick();
        n_cmp++; if (q !== 4'h0)    begin n_err++; $display("FAIL settle_q got %h expected 0", q); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL settle_busy got %b expected 0", busy); end
        $display("settle: q=%h busy=%b", q, busy);
    endtask

    // Bounce channel 0 as 1,0,1,0 with 3 clocks per level, then hold it high.
    task automatic test_bounce();
        int n_rise0 = 0;
        for (int p = 0; p < 4; p++) begin
            din[0] = (p % 2 == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (rise[0]) n_rise0++;
                n_cmp++; if (q[0] !== 1'b0) begin n_err++; $display("FAIL bounce_q phase %0d cyc %0d got %b expected 0", p, c, q[0]); end
            end
            $display("bounce phase %0d: din0=%b q0=%b", p, din[0], q[0]);
        end
        din[0] = 1'b1;
        for (int k = 0; k <= LAT + 2; k++) begin
            tick();
            if (rise[0]) n_rise0++;
            n_cmp++; if (q[0] !== (k >= LAT)) begin n_err++; $display("FAIL bounce_hold_q E%0d got %b expected %b", k, q[0], (k >= LAT)); end
            n_cmp++; if (rise[0] !== (k == LAT)) begin n_err++; $display("FAIL bounce_hold_rise E%0d got %b expected %b", k, rise[0], (k == LAT)); end
        end
        n_cmp++; if (n_rise0 !== 1) begin n_err++; $display("FAIL bounce_rise_count got %0d expected 1", n_rise0); end
        $display("bounce: q=%h rise0 pulses=%0d", q, n_rise0);
    endtask

    // Hold din[1] high for 7 clocks only. The pulse must never reach q[1].
    task automatic test_short_pulse();
        logic seen_busy = 1'b0;
        din[1] = 1'b1;
        repeat (7) begin
            tick();
            if (busy) seen_busy = 1'b1;
        end
        din[1] = 1'b0;
        for (int k = 0; k <= LAT + 3; k++) begin
            tick();
            if (busy) seen_busy = 1'b1;
            n_cmp++; if (q !== 4'b0001) begin n_err++; $display("FAIL short_q cyc %0d got %h expected 1", k, q); end
            n_cmp++; if (rise !== 4'h0) begin n_err++; $display("FAIL short_rise cyc %0d got %h expected 0", k, rise); end
        end
        n_cmp++; if (seen_busy !== 1'b1) begin n_err++; $display("FAIL short_busy_seen got %b expected 1", seen_busy); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL short_busy_end got %b expected 0", busy); end
        $display("short pulse: q=%h busy_seen=%b busy=%b", q, seen_busy, busy);
    endtask

    // Raise din[2], then pulse reset low 5 clocks later for 2 clocks.
    task automatic test_reset_midcount();
        logic [3:0] eq, er;
        din[2] = 1'b1;
        repeat (5) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        n_cmp++; if (q !== 4'h0)    begin n_err++; $display("FAIL midrst_async_q got %h expected 0", q); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_async_busy got %b expected 0", busy); end
        $display("mid reset asserted: q=%h busy=%b", q, busy);
        repeat (2) tick();
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL midrst_hold_q got %h expected 0", q); end
        reset = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            eq = (k >= LAT) ? 4'b0101 : 4'b0000;
            er = (k == LAT) ? 4'b0101 : 4'b0000;
            n_cmp++; if (q !== eq)    begin n_err++; $display("FAIL midrst_q E%0d got %h expected %h", k, q, eq); end
            n_cmp++; if (rise !== er) begin n_err++; $display("FAIL midrst_rise E%0d got %h expected %h", k, rise, er); end
        end
        $display("mid reset recovery: q=%h", q);
    endtask

    initial begin
        reset = 1'b0;
        din   = 4'h0;
        test_reset();
        test_independent_fall();
        test_settle();
        test_bounce();
        test_short_pulse();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
